// File: rtl/ibex_rf_cache_pkg.sv
// Shared types for the register-file cache fill controller and its LRU tracker.
package ibex_rf_cache_pkg;

    localparam int unsigned CacheLenDef = 4;

    typedef logic [$clog2(CacheLenDef)-1:0] way_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } fill_state_e;

endpackage

// File: rtl/ibex_rf_cache_lru.sv
// Age-based LRU tracker: up to three touches per cycle and an excluded-way victim pick.
module ibex_rf_cache_lru
    import ibex_rf_cache_pkg::*;
#(
    parameter  int unsigned CacheLen = CacheLenDef,
    localparam int unsigned WayW     = $clog2(CacheLen)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CacheLen-1:0] valid_i,
    input  logic                touch_a_i,
    input  logic [WayW-1:0]     touch_a_way_i,
    input  logic                touch_b_i,
    input  logic [WayW-1:0]     touch_b_way_i,
    input  logic                touch_w_i,
    input  logic [WayW-1:0]     touch_w_way_i,
    input  logic [CacheLen-1:0] excl_i,
    output logic [WayW-1:0]     victim_o
);

    typedef logic [CacheLen-1:0][WayW-1:0] ages_t;

    ages_t         age_q, age_d;
    logic [WayW:0] pick_masked, pick_any;

    // Touching an invalid way (allocation) ages every valid way, keeping ages a permutation.
    function automatic ages_t touch(input ages_t ages, input logic [CacheLen-1:0] valid,
                                    input logic [WayW-1:0] way);
        touch = ages;
        for (int i = 0; i < int'(CacheLen); i++) begin
            if (valid[i] && (i != int'(way)) && (!valid[way] || (ages[i] < ages[way]))) begin
                touch[i] = ages[i] + 1'b1;
            end
        end
        touch[way] = '0;
    endfunction

    function automatic logic [WayW:0] pick(input ages_t ages, input logic [CacheLen-1:0] valid,
                                           input logic [CacheLen-1:0] ok);
        logic            found_inv, found_old;
        logic [WayW-1:0] w_inv, w_old, best;
        found_inv = 1'b0;
        found_old = 1'b0;
        w_inv     = '0;
        w_old     = '0;
        best      = '0;
        for (int i = int'(CacheLen) - 1; i >= 0; i--) begin
            if (ok[i] && !valid[i]) begin
                found_inv = 1'b1;
                w_inv     = WayW'(i);
            end
        end
        for (int i = 0; i < int'(CacheLen); i++) begin
            if (ok[i] && valid[i] && (!found_old || (ages[i] > best))) begin
                found_old = 1'b1;
                best      = ages[i];
                w_old     = WayW'(i);
            end
        end
        pick = {found_inv | found_old, found_inv ? w_inv : w_old};
    endfunction

    assign pick_masked = pick(age_q, valid_i, ~excl_i);
    assign pick_any    = pick(age_q, valid_i, '1);
    assign victim_o    = pick_masked[WayW] ? pick_masked[WayW-1:0] : pick_any[WayW-1:0];

    // Most recent access is applied last so it ends up youngest.
    always_comb begin
        age_d = age_q;
        if (touch_b_i) age_d = touch(age_d, valid_i, touch_b_way_i);
        if (touch_a_i) age_d = touch(age_d, valid_i, touch_a_way_i);
        if (touch_w_i) age_d = touch(age_d, valid_i, touch_w_way_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/ibex_rf_cache_fill_ctrl.sv
// Register-file cache miss/fill controller: tags, valids, hit flags, refill FSM and
// write-allocate arbitration of the single data-array write port.
module ibex_rf_cache_fill_ctrl
    import ibex_rf_cache_pkg::*;
#(
    parameter  int unsigned CacheLen  = CacheLenDef,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned AddrWidth = 5,
    localparam int unsigned WayW      = $clog2(CacheLen)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_a_req_i,
    input  logic [AddrWidth-1:0] rd_a_addr_i,
    input  logic                 rd_b_req_i,
    input  logic [AddrWidth-1:0] rd_b_addr_i,
    input  logic                 wr_req_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 hit_a_o,
    output logic [WayW-1:0]      way_a_o,
    output logic                 hit_b_o,
    output logic [WayW-1:0]      way_b_o,
    output logic                 stall_o,
    output logic                 rf_req_o,
    output logic [AddrWidth-1:0] rf_addr_o,
    input  logic                 rf_gnt_i,
    input  logic                 rf_rvalid_i,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 fill_we_o,
    output logic [WayW-1:0]      fill_way_o,
    output logic [DataWidth-1:0] fill_data_o
);

    fill_state_e                        state_q, state_d;
    logic [CacheLen-1:0]                valid_q, valid_d;
    logic [CacheLen-1:0][AddrWidth-1:0] tag_q, tag_d;
    logic [AddrWidth-1:0]               addr_q, addr_d;
    logic [DataWidth-1:0]               data_q, data_d;
    logic                               squash_q, squash_d;

    logic [WayW:0]       lk_a, lk_b, lk_w;
    logic                match_a, match_b, miss_a, miss_b;
    logic                wr_act, wr_alloc, squash_hit;
    logic [WayW-1:0]     victim, wr_way;
    logic [CacheLen-1:0] excl;

    function automatic logic [WayW:0] lookup(input logic [AddrWidth-1:0] addr,
                                             input logic [CacheLen-1:0] valid,
                                             input logic [CacheLen-1:0][AddrWidth-1:0] tag);
        lookup = '0;
        for (int i = int'(CacheLen) - 1; i >= 0; i--) begin
            if (valid[i] && (tag[i] == addr)) lookup = {1'b1, WayW'(i)};
        end
    endfunction

    assign lk_a = lookup(rd_a_addr_i, valid_q, tag_q);
    assign lk_b = lookup(rd_b_addr_i, valid_q, tag_q);
    assign lk_w = lookup(wr_addr_i, valid_q, tag_q);

    // x0 is never tagged, so it reports a hit without a way.
    assign match_a = rd_a_req_i & lk_a[WayW];
    assign match_b = rd_b_req_i & lk_b[WayW];
    assign hit_a_o = rd_a_req_i & ((rd_a_addr_i == '0) | lk_a[WayW]);
    assign hit_b_o = rd_b_req_i & ((rd_b_addr_i == '0) | lk_b[WayW]);
    assign way_a_o = match_a ? lk_a[WayW-1:0] : '0;
    assign way_b_o = match_b ? lk_b[WayW-1:0] : '0;
    assign miss_a  = rd_a_req_i & ~hit_a_o;
    assign miss_b  = rd_b_req_i & ~hit_b_o;

    assign wr_act     = wr_req_i & (wr_addr_i != '0);
    assign wr_alloc   = wr_act & ~lk_w[WayW];
    assign wr_way     = lk_w[WayW] ? lk_w[WayW-1:0] : victim;
    assign squash_hit = wr_act & (wr_addr_i == addr_q);

    assign stall_o   = miss_a | miss_b | (state_q != IDLE);
    assign rf_req_o  = (state_q == REQ);
    assign rf_addr_o = rf_req_o ? addr_q : '0;

    always_comb begin
        excl = '0;
        if (match_a) excl[lk_a[WayW-1:0]] = 1'b1;
        if (match_b) excl[lk_b[WayW-1:0]] = 1'b1;
    end

    ibex_rf_cache_lru #(
        .CacheLen(CacheLen)
    ) u_lru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_q),
        .touch_a_i    (match_a),
        .touch_a_way_i(lk_a[WayW-1:0]),
        .touch_b_i    (match_b),
        .touch_b_way_i(lk_b[WayW-1:0]),
        .touch_w_i    (fill_we_o),
        .touch_w_way_i(fill_way_o),
        .excl_i       (excl),
        .victim_o     (victim)
    );

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        addr_d      = addr_q;
        data_d      = data_q;
        squash_d    = squash_q;
        fill_we_o   = 1'b0;
        fill_way_o  = '0;
        fill_data_o = '0;
        if (wr_act) begin
            fill_we_o       = 1'b1;
            fill_way_o      = wr_way;
            fill_data_o     = wr_data_i;
            valid_d[wr_way] = 1'b1;
            tag_d[wr_way]   = wr_addr_i;
        end
        case (state_q)
            IDLE: begin
                squash_d = 1'b0;
                if (!wr_alloc && (miss_a || miss_b)) begin
                    state_d = REQ;
                    addr_d  = miss_a ? rd_a_addr_i : rd_b_addr_i;
                end
            end
            REQ: begin
                if (squash_hit) squash_d = 1'b1;
                if (rf_gnt_i)   state_d  = WAIT;
            end
            WAIT: begin
                if (squash_hit) squash_d = 1'b1;
                if (rf_rvalid_i) begin
                    data_d  = rf_rdata_i;
                    state_d = (squash_q || squash_hit) ? IDLE : FILL;
                end
            end
            FILL: begin
                // data_q holds the refill while a concurrent write owns the port.
                if (squash_hit) begin
                    state_d = IDLE;
                end else if (!wr_act) begin
                    fill_we_o       = 1'b1;
                    fill_way_o      = victim;
                    fill_data_o     = data_q;
                    valid_d[victim] = 1'b1;
                    tag_d[victim]   = addr_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            squash_q <= squash_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
